// File: rtl/tank_pkg.sv
// Shared constants for the tank game blocks.
//   DIR_*        : 2-bit direction encoding used on every tank/bullet bus
//   DEF_*        : default sizes for tank count, bullet slot count, coordinate width
//   PLAYER_ID    : requester index of the player tank
package tank_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int DEF_POS_W  = 5;
  localparam int DEF_N_TANK = 4;
  localparam int DEF_N_SLOT = 4;

  localparam int PLAYER_ID = 0;

  // Width of an index into n things, never below 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req : request vector, one bit per requester
//   ptr : index that gets first look this cycle
//   gnt : one-hot grant (all zero when nothing requests)
//   vld : a grant was made
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  logic [PW-1:0] idx;

  // Walk the requesters starting at ptr, wrapping once; first hit wins.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!vld && req[idx]) begin
        gnt[idx] = 1'b1;
        vld      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bullet_slot_arbiter.sv
// Bullet slot arbiter: shares N_SLOT bullet slots among N_TANK tanks.
// One round-robin winner per cycle gets the lowest free slot; the slot is
// launched with the winner's position/direction and held until the bullet
// mover has raised and then dropped slot_busy.
//   clk, rst_n      : clock, async active-low reset
//   tick_en         : game tick, cooldown time base
//   game_en         : grant enable
//   sht_req         : level shoot request per tank
//   tank_x/y/dir    : per-tank position and facing (packed by tank index)
//   slot_busy       : per-slot occupancy from the bullet movers
//   launch          : per-slot start pulse
//   launch_x/y/dir  : per-slot start state, held until the slot relaunches
//   slot_owner      : per-slot owning tank index
//   sht_ack         : per-tank grant pulse
//   tank_live       : per-tank bullet in flight
module bullet_slot_arbiter
  import tank_pkg::*;
#(
  parameter int N_TANK   = DEF_N_TANK,
  parameter int N_SLOT   = DEF_N_SLOT,
  parameter int POS_W    = DEF_POS_W,
  parameter int COOLDOWN = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_en,
  input  logic                    game_en,
  input  logic [N_TANK-1:0]       sht_req,
  input  logic [N_TANK*POS_W-1:0] tank_x,
  input  logic [N_TANK*POS_W-1:0] tank_y,
  input  logic [N_TANK*2-1:0]     tank_dir,
  input  logic [N_SLOT-1:0]       slot_busy,
  output logic [N_SLOT-1:0]       launch,
  output logic [N_SLOT*POS_W-1:0] launch_x,
  output logic [N_SLOT*POS_W-1:0] launch_y,
  output logic [N_SLOT*2-1:0]     launch_dir,
  output logic [N_SLOT*2-1:0]     slot_owner,
  output logic [N_TANK-1:0]       sht_ack,
  output logic [N_TANK-1:0]       tank_live
);

  localparam int PW = idx_w(N_TANK);
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [PW-1:0]              ptr;
  logic [N_TANK-1:0]          live;
  logic [N_TANK-1:0][CW-1:0]  cool;
  logic [N_SLOT-1:0]          alloc, seen;

  logic [N_SLOT-1:0]          free_oh, rel;
  logic [N_TANK-1:0]          elig, gnt, rel_tank;
  logic                       gnt_vld, any_free;
  logic [PW-1:0]              win;
  logic [POS_W-1:0]           win_x, win_y;
  logic [1:0]                 win_dir;

  assign tank_live = live;
  assign any_free  = ~&alloc;
  // Lowest clear bit of alloc: adding 1 ripples through the low ones.
  assign free_oh   = ~alloc & (alloc + 1'b1);
  // A slot is done once its mover has shown busy and then dropped it.
  assign rel       = alloc & seen & ~slot_busy;

  always_comb begin
    elig     = '0;
    rel_tank = '0;
    for (int i = 0; i < N_TANK; i++) begin
      elig[i] = sht_req[i] & ~live[i] & (cool[i] == '0) & game_en & any_free;
      for (int s = 0; s < N_SLOT; s++)
        if (rel[s] && slot_owner[s*2 +: 2] == 2'(i)) rel_tank[i] = 1'b1;
    end
  end

  rr_arbiter #(.N(N_TANK), .PW(PW)) u_rr (
    .req (elig),
    .ptr (ptr),
    .gnt (gnt),
    .vld (gnt_vld)
  );

  // Encode the one-hot winner and mux its launch state.
  always_comb begin
    win     = '0;
    win_x   = '0;
    win_y   = '0;
    win_dir = DIR_UP;
    for (int i = 0; i < N_TANK; i++) begin
      if (gnt[i]) begin
        win     = PW'(i);
        win_x   = tank_x[i*POS_W +: POS_W];
        win_y   = tank_y[i*POS_W +: POS_W];
        win_dir = tank_dir[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      live       <= '0;
      cool       <= '0;
      alloc      <= '0;
      seen       <= '0;
      launch     <= '0;
      sht_ack    <= '0;
      launch_x   <= '0;
      launch_y   <= '0;
      launch_dir <= '0;
      slot_owner <= '0;
    end else begin
      launch  <= gnt_vld ? free_oh : '0;
      sht_ack <= gnt;
      if (gnt_vld)
        ptr <= (int'(win) == N_TANK - 1) ? '0 : win + 1'b1;

      for (int s = 0; s < N_SLOT; s++) begin
        if (rel[s]) begin
          alloc[s] <= 1'b0;
          seen[s]  <= 1'b0;
        end else if (alloc[s] && slot_busy[s]) begin
          seen[s] <= 1'b1;
        end
        // Grants only target free slots, so this never collides with a release.
        if (gnt_vld && free_oh[s]) begin
          alloc[s]                   <= 1'b1;
          seen[s]                    <= 1'b0;
          slot_owner[s*2 +: 2]       <= 2'(win);
          launch_x[s*POS_W +: POS_W] <= win_x;
          launch_y[s*POS_W +: POS_W] <= win_y;
          launch_dir[s*2 +: 2]       <= win_dir;
        end
      end

      for (int i = 0; i < N_TANK; i++) begin
        // A grant reloads the cooldown even on a tick.
        if (gnt[i])
          cool[i] <= CW'(COOLDOWN);
        else if (tick_en && cool[i] != '0)
          cool[i] <= cool[i] - 1'b1;

        if (gnt[i])
          live[i] <= 1'b1;
        else if (rel_tank[i])
          live[i] <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bullet_slot_arbiter.md
# bullet_slot_arbiter

Shares the four on-screen bullet slots among the player tank and the three enemy tanks. It accepts shoot requests and picks one winner per cycle by round-robin. It allocates the winner the lowest free slot and launches that slot with the shooter's position and direction. It then tracks slot ownership until the bullet mover releases the slot. The block sits between the tank application modules (which raise shoot requests) and the bullet mover modules (which report slot occupancy).

## Interface
Parameters:
- `N_TANK`, default 4: number of requesters; index 0 is the player tank.
- `N_SLOT`, default 4: number of bullet slots.
- `POS_W`, default 5: coordinate width in grid cells.
- `COOLDOWN`, default 2: ticks of `tick_en` a tank must wait after a grant before its next grant.

Ports (clock and reset first):
- `clk`, in, 1: system clock; everything is synchronous to its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `tick_en`, in, 1: one-cycle game-tick pulse (4 Hz rate); acts as the cooldown time base.
- `game_en`, in, 1: when low, no new grants are issued.
- `sht_req`, in, N_TANK: level shoot request, one bit per tank.
- `tank_x`, in, N_TANK*POS_W: x position per tank, packed with tank i at `[i*POS_W +: POS_W]`.
- `tank_y`, in, N_TANK*POS_W: y position per tank, packed the same way.
- `tank_dir`, in, N_TANK*2: direction per tank (00 up, 01 down, 10 left, 11 right).
- `slot_busy`, in, N_SLOT: slot occupancy reported by the bullet movers.
- `launch`, out, N_SLOT: one-cycle pulse that starts the bullet in a slot.
- `launch_x`, out, N_SLOT*POS_W: start x per slot; held stable until the next launch of that slot.
- `launch_y`, out, N_SLOT*POS_W: start y per slot; held stable the same way.
- `launch_dir`, out, N_SLOT*2: start direction per slot; held stable the same way.
- `slot_owner`, out, N_SLOT*2: tank index that owns each slot.
- `sht_ack`, out, N_TANK: one-cycle grant pulse to the winning tank.
- `tank_live`, out, N_TANK: tank currently has a bullet in flight.

## Operation
Per-tank state:
- `live` bit.
- Cooldown counter with range 0..COOLDOWN.

Per-slot state:
- `alloc` bit.
- `seen` bit.
- `owner` index.

A tank is eligible only when all of these hold:
- `sht_req[i]` = 1
- `live[i]` = 0
- `cool[i]` = 0
- `game_en` = 1
- At least one slot has `alloc` = 0.

Arbitration:
- Round-robin over eligible tanks, starting at the pointer.
- After a grant, the pointer moves to winner+1 (mod N_TANK).
- The slot is the lowest index with `alloc` = 0.

Effects of a grant, all registered and visible the next cycle:
- `sht_ack[w]` pulses.
- `launch[s]` pulses.
- `launch_x/y/dir[s]` take the winner's inputs from the request cycle.
- `alloc[s]`=1, `seen[s]`=0, `owner[s]`=w.
- `live[w]`=1, `cool[w]`=COOLDOWN.

Slot release:
- `seen[s]` sets when `alloc[s]`=1 and `slot_busy[s]`=1.
- The slot releases when `alloc`=1, `seen`=1 and `slot_busy`=0.
- On release, `alloc[s]`=0 and `live[owner[s]]`=0.
- Bullet movers must raise `slot_busy` no later than 1 cycle after `launch`.

Cooldown:
- On `tick_en`, every nonzero `cool[i]` decrements.
- A grant in the same cycle as a tick loads COOLDOWN; the load wins.

Boundary cases:
- A release and a new request in the same cycle: the freed slot and the owning tank become eligible the following cycle. `alloc` and `live` are registered, so there is no same-cycle reuse.
- All slots allocated: requests stall. The level request is simply re-evaluated each cycle, and no request is lost while held.
- `game_en` low: grants are blocked. In-flight tracking, releases and cooldown continue.
- `slot_busy` high on an unallocated slot is ignored.

## Timing
- Latency from request to `sht_ack`/`launch`: 1 cycle.
- Throughput: at most one grant per cycle.

Reset values (asynchronous, on `rst_n`=0):
- `launch`, `sht_ack`, `tank_live`: 0.
- `launch_x`, `launch_y`: 0.
- `launch_dir`: 00.
- `slot_owner`: 0.
- All `alloc`, `seen`, `cool` cleared; pointer = 0.
- A reset in mid-flight forgets every allocation. After reset, all slots are treated as free regardless of `slot_busy`.

## Structure
- Shared `tank_pkg` holds:
  - Direction constants `DIR_UP`=2'b00, `DIR_DOWN`=2'b01, `DIR_LEFT`=2'b10, `DIR_RIGHT`=2'b11.
  - `POS_W`, `N_TANK`, `N_SLOT` defaults.
  - The player index constant `PLAYER_ID`=0.
- Sub-module `rr_arbiter`: combinational N-way round-robin pick from a request vector and pointer. It returns a one-hot grant and a valid flag. The pointer register stays in the parent.
- Free-slot priority encoding is inline in the parent.

## Test plan
- Single request: reset, then tank 0 requests at (7,7) facing up. Next cycle `sht_ack`=0001 and `launch`=0001, with `launch_x/y`=7/7, dir 00 and `slot_owner[0]`=0. Raise `slot_busy[0]` one cycle later. `tank_live[0]` stays 1 while busy and falls 1 cycle after `slot_busy[0]` drops.
- Round-robin: all 4 tanks request continuously. Grants go in order 0, 1, 2, 3 on consecutive cycles into slots 0, 1, 2, 3. The fifth cycle has no grant because all slots are allocated.
- Cooldown: with COOLDOWN=2, tank 1 fires, its slot is released, and it keeps requesting. No grant occurs until 2 `tick_en` pulses have passed; the grant comes 1 cycle after the second tick.
- Slot exhaustion and release: all slots are busy. Drop `slot_busy[2]`, and in the same cycle tank 3's request becomes eligible. Slot 2 launches exactly 2 cycles after the drop, not 1.
- `game_en`=0 with requests held: no `launch` for 10 cycles, while in-flight releases still clear `tank_live`. Raise `game_en`: a grant follows 1 cycle later.
- Reset mid-flight: 3 slots allocated, then assert `rst_n` low for 1 cycle. All outputs go to 0 immediately. After release, a tank 0 request launches in slot 0 even though `slot_busy`=1111.
